// File: rtl/writeback_stage_if.sv
// Bundle seen by the writeback stage: the memory-stage bundle and pipeline
// controls coming in, and the register-file write port plus status going out.
interface writeback_stage_if #(
  parameter int CNT_W = 16
);
  logic [38:0]      W_in;
  logic             valid_M;
  logic             stall_W;
  logic             flush_W;
  logic             wb_en;
  logic [3:0]       wb_reg;
  logic [15:0]      wb_data;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output W_in, valid_M, stall_W, flush_W,
    input  wb_en, wb_reg, wb_data, halted, retired
  );

  modport slave (
    input  W_in, valid_M, stall_W, flush_W,
    output wb_en, wb_reg, wb_data, halted, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: M/W register, writeback mux, sticky halt detection
// and retired-instruction counter.
module writeback_stage #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  writeback_stage_if.slave wb
);

  logic             r_valid;
  logic [15:0]      r_alu;
  logic [15:0]      r_mem;
  logic [3:0]       r_reg;
  logic             r_halt;
  logic             r_rw;
  logic             r_m2r;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  logic             w_retire;

  // The entry in M/W leaves the pipeline on this edge; a stall keeps it
  // in place, so it is counted only once, when the stall lifts.
  assign w_retire = r_valid & ~wb.stall_W & ~r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_alu   <= 16'h0000;
      r_mem   <= 16'h0000;
      r_reg   <= 4'h0;
      r_halt  <= 1'b0;
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
    end else if (!r_halted) begin
      if (wb.flush_W) begin
        r_valid <= 1'b0;
        r_alu   <= 16'h0000;
        r_mem   <= 16'h0000;
        r_reg   <= 4'h0;
        r_halt  <= 1'b0;
        r_rw    <= 1'b0;
        r_m2r   <= 1'b0;
      end else if (!wb.stall_W) begin
        r_valid <= wb.valid_M;
        r_alu   <= wb.W_in[38:23];
        r_mem   <= wb.W_in[22:7];
        r_reg   <= wb.W_in[6:3];
        r_halt  <= wb.W_in[2];
        r_rw    <= wb.W_in[1];
        r_m2r   <= wb.W_in[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
      if (r_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  // R0 is hardwired zero, and nothing commits once the core has halted.
  assign wb.wb_en   = r_valid & r_rw & (r_reg != 4'h0) & ~r_halted;
  assign wb.wb_reg  = r_reg;
  assign wb.wb_data = r_m2r ? r_mem : r_alu;
  assign wb.halted  = r_halted;
  assign wb.retired = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage; a 4-bit-counter copy runs
// on the same stimulus to exercise counter wrap.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic [38:0] tbWin;
  logic        tbValid;
  logic        tbStall;
  logic        tbFlush;

  int nChecks = 0;
  int nFail   = 0;

  writeback_stage_if #(.CNT_W(16)) wbIf ();
  writeback_stage_if #(.CNT_W(4))  wbIf4 ();

  assign wbIf.W_in     = tbWin;
  assign wbIf.valid_M  = tbValid;
  assign wbIf.stall_W  = tbStall;
  assign wbIf.flush_W  = tbFlush;
  assign wbIf4.W_in    = tbWin;
  assign wbIf4.valid_M = tbValid;
  assign wbIf4.stall_W = tbStall;
  assign wbIf4.flush_W = tbFlush;

  writeback_stage #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbIf.slave)
  );

  writeback_stage #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbIf4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        en;
    logic [3:0]  rg;
    logic [15:0] data;
    logic        hl;
    logic [15:0] ret;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [38:0] mk(input logic [15:0] alu, input logic [15:0] mem,
                                     input logic [3:0] rg, input logic hlt,
                                     input logic rw, input logic m2r);
    return {alu, mem, rg, hlt, rw, m2r};
  endfunction

  task automatic pushExp(input string tag, input logic en, input logic [3:0] rg,
                         input logic [15:0] data, input logic hl, input logic [15:0] ret);
    exp_t e;
    e.tag  = tag;
    e.en   = en;
    e.rg   = rg;
    e.data = data;
    e.hl   = hl;
    e.ret  = ret;
    sbq.push_back(e);
  endtask

  task automatic checkOutput;
    exp_t e;
    nChecks++;
    assert (sbq.size() != 0) else begin
      nFail++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      nChecks++;
      assert (wbIf.wb_en === e.en) else begin
        nFail++;
        $error("FAIL %s wb_en: observed %b expected %b", e.tag, wbIf.wb_en, e.en);
      end
      nChecks++;
      assert (wbIf.wb_reg === e.rg) else begin
        nFail++;
        $error("FAIL %s wb_reg: observed %0d expected %0d", e.tag, wbIf.wb_reg, e.rg);
      end
      nChecks++;
      assert (wbIf.wb_data === e.data) else begin
        nFail++;
        $error("FAIL %s wb_data: observed %h expected %h", e.tag, wbIf.wb_data, e.data);
      end
      nChecks++;
      assert (wbIf.halted === e.hl) else begin
        nFail++;
        $error("FAIL %s halted: observed %b expected %b", e.tag, wbIf.halted, e.hl);
      end
      nChecks++;
      assert (wbIf.retired === e.ret) else begin
        nFail++;
        $error("FAIL %s retired: observed %0d expected %0d", e.tag, wbIf.retired, e.ret);
      end
      nChecks++;
      assert (wbIf4.retired === e.ret[3:0]) else begin
        nFail++;
        $error("FAIL %s retired4: observed %0d expected %0d", e.tag, wbIf4.retired, e.ret[3:0]);
      end
    end
  endtask

  // One directed step: drive on the falling edge, check just after the rising edge.
  task automatic applyStimulus(input logic [38:0] w, input logic vm, input logic st,
                               input logic fl, input string tag, input logic en,
                               input logic [3:0] rg, input logic [15:0] data,
                               input logic hl, input logic [15:0] ret);
    @(negedge clk);
    tbWin   = w;
    tbValid = vm;
    tbStall = st;
    tbFlush = fl;
    pushExp(tag, en, rg, data, hl, ret);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    tbWin   = '0;
    tbValid = 1'b0;
    tbStall = 1'b0;
    tbFlush = 1'b0;
    #1;
    pushExp(tag, 1'b0, 4'h0, 16'h0000, 1'b0, 16'd0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    tbWin   = '0;
    tbValid = 1'b0;
    tbStall = 1'b0;
    tbFlush = 1'b0;
    doReset("rst_init");

    // All-ones entry, then reset asserted mid-cycle must clear outputs at once.
    applyStimulus({39{1'b1}}, 1'b1, 1'b0, 1'b0, "ones_load", 1'b1, 4'hF, 16'hFFFF, 1'b0, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    pushExp("rst_async", 1'b0, 4'h0, 16'h0000, 1'b0, 16'd0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pushExp("rst_release", 1'b1, 4'hF, 16'hFFFF, 1'b0, 16'd0);
    checkOutput();
    doReset("rst_clear");

    // ALU and load writeback, R0 write, bubble.
    applyStimulus(mk(16'h1234, 16'h0000, 4'd3, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0,
                  "alu_op", 1'b1, 4'd3, 16'h1234, 1'b0, 16'd0);
    applyStimulus(mk(16'h0000, 16'hBEEF, 4'd5, 1'b0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0,
                  "load_op", 1'b1, 4'd5, 16'hBEEF, 1'b0, 16'd1);
    applyStimulus(mk(16'h5555, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0,
                  "r0_write", 1'b0, 4'd0, 16'h5555, 1'b0, 16'd2);
    applyStimulus(mk(16'h7777, 16'h0000, 4'd6, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0,
                  "bubble", 1'b0, 4'd6, 16'h7777, 1'b0, 16'd3);

    // Three-cycle stall holds the entry and counts it once afterwards.
    applyStimulus(mk(16'h00AA, 16'h0000, 4'd7, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0,
                  "stall_setup", 1'b1, 4'd7, 16'h00AA, 1'b0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(16'h1111, 16'h0000, 4'd8, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0,
                    "stall_hold", 1'b1, 4'd7, 16'h00AA, 1'b0, 16'd3);
    end
    applyStimulus(mk(16'h2222, 16'h0000, 4'd9, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0,
                  "stall_end", 1'b1, 4'd9, 16'h2222, 1'b0, 16'd4);
    applyStimulus(mk(16'hDEAD, 16'hBEEF, 4'd10, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1,
                  "flush_stall", 1'b0, 4'd0, 16'h0000, 1'b0, 16'd4);
    applyStimulus(mk(16'h3333, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0,
                  "after_flush", 1'b1, 4'd4, 16'h3333, 1'b0, 16'd4);
    applyStimulus(mk(16'h4321, 16'h0000, 4'd11, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b1,
                  "flush_only", 1'b0, 4'd0, 16'h0000, 1'b0, 16'd5);

    // HLT followed by ADD: halt rises one edge later, ADD never commits.
    applyStimulus(mk(16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0,
                  "hlt_load", 1'b0, 4'd0, 16'h0000, 1'b0, 16'd5);
    applyStimulus(mk(16'h4444, 16'h0000, 4'd2, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0,
                  "hlt_retire", 1'b0, 4'd2, 16'h4444, 1'b1, 16'd6);
    applyStimulus(mk(16'h5555, 16'h0000, 4'd3, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0,
                  "hlt_frozen", 1'b0, 4'd2, 16'h4444, 1'b1, 16'd6);
    doReset("rst_after_hlt");

    // Seventeen retirements: the 4-bit copy wraps to 1.
    for (int j = 0; j < 17; j++) begin
      applyStimulus(mk(16'(j), 16'h0000, 4'd1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0,
                    "wrap_step", 1'b1, 4'd1, 16'(j), 1'b0, 16'(j));
    end
    applyStimulus(39'd0, 1'b0, 1'b0, 1'b0, "wrap_final", 1'b0, 4'd0, 16'h0000, 1'b0, 16'd17);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the five-stage processor. Holds the M/W pipeline register and captures the 39-bit bundle from the memory stage each cycle. Selects between ALU result and loaded data, and drives the register-file write port. Also owns halt detection (sticky `halted` for the testbench/top level) and a retired-instruction counter.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `W_in`  in  39  bundle from memory stage:
  - [38:23] ALU result.
  - [22:7] memory read data.
  - [6:3] destination register.
  - [2] halt.
  - [1] RegWrite.
  - [0] MemtoReg.
- `valid_M`  in  1  `W_in` carries a real instruction (0 = bubble).
- `stall_W`  in  1  hold the M/W register contents.
- `flush_W`  in  1  load a bubble instead of `W_in`.
- `wb_en`  out  1  register-file write enable.
- `wb_reg`  out  4  register-file write address.
- `wb_data`  out  16  register-file write data.
- `halted`  out  1  sticky; the processor has retired HLT.
- `retired`  out  `CNT_W`  count of retired instructions, including HLT.

## Operation
- **M/W register fields:** `valid_W`, `alu_W[15:0]`, `mem_W[15:0]`, `reg_W[3:0]`, `halt_W`, `rw_W`, `m2r_W`.
- **Load rule on each rising edge, in priority order:**
  - `halted`=1 → hold (frozen).
  - `flush_W`=1 → `valid_W`←0; other fields don't-care, implementation clears them to 0.
  - `stall_W`=1 → hold.
  - else → load `W_in`, `valid_W`←`valid_M`.
- **Write data:** `wb_data` = `m2r_W` ? `mem_W` : `alu_W`.
- **Write address:** `wb_reg` = `reg_W`.
- **Write enable:** `wb_en` = `valid_W` & `rw_W` & (`reg_W`≠0) & ~`halted`. R0 is never written.
- **Halt:** on an edge where `valid_W`=1, `halt_W`=1, `stall_W`=0 and `halted`=0, `halted`←1. It stays 1 until reset.
- **Retired counter:** on an edge where `valid_W`=1, `stall_W`=0 and `halted`=0, `retired`←`retired`+1, modulo 2^`CNT_W`. It wraps from all-ones to 0 silently.
- **Stall rewrite:** during a stall, `wb_en` stays asserted for a valid writing entry, so the same register is rewritten with the same value. This is harmless, and the counter does not double-count.
- **Flush and stall together:** flush wins; the register becomes a bubble. The outgoing entry still counts as retired if `valid_W`=1 — no, it does not: `stall_W`=1 inhibits the count, and the entry is discarded.
- **Bubble:** a bubble (`valid_W`=0) produces `wb_en`=0, no count and no halt, regardless of the other fields.

## Timing
- **Reset:** asynchronous on `rst_n` low. All M/W fields←0, `halted`←0, `retired`←0.
  - Outputs during and after reset: `wb_en`=0, `wb_reg`=0, `wb_data`=0.
  - Takes effect mid-stall or mid-halt immediately. Release is synchronous to the next edge.
- **Latency:** `W_in` sampled at edge k appears on `wb_*` combinationally after edge k. The register file commits it at edge k+1.
- **Halt timing:** HLT loaded at edge k; `halted` rises after edge k+1 if not stalled at k+1.
  - HLT's own `wb_en` is 0 (RegWrite=0 from decode).
  - Instructions behind HLT are never committed.
- **Combinational paths:** `wb_*` are pure functions of registered state plus `halted`. There is no combinational path from `W_in`, `stall_W` or `flush_W` to any output.

## Test plan
- **Reset:** drive `W_in`=all ones, `valid_M`=1, assert `rst_n`=0 mid-cycle → all outputs 0 immediately. After release and one edge, `wb_en`=1, `wb_reg`=15, `wb_data`=FFFF (MemtoReg=1 selects mem field).
- **ALU and load writeback:** ALU op (alu=0x1234, reg=3, rw=1, m2r=0) then load (mem=0xBEEF, reg=5, m2r=1) on consecutive edges.
  - Expected: `wb_en`=1 with 3/1234, then 5/BEEF.
  - Expected: `retired` increments 1, 2.
- **R0 and bubbles:** entry with reg=0, rw=1 → `wb_en`=0, `retired` still increments. `valid_M`=0 → `wb_en`=0, no increment.
- **Stall and flush:** stall 3 cycles on reg=7/0x00AA → `wb_en` held at 1 with the same data, `retired` increments exactly once (after the stall ends). Flush with stall → bubble, no increment.
- **Halt:** HLT then ADD reg=2 → `halted`=1 one edge after HLT loads, `retired` counts HLT, ADD never produces `wb_en`=1. Then pulse `rst_n` → `halted`=0, `retired`=0.
- **Counter wrap:** `CNT_W`=4, retire 17 valid instructions → `retired`=1.
